// File: rtl/scan_pkg.sv
// Shared types and sizing helpers for the scan sequencer and its dwell timer.
package scan_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BLANK  = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   localparam int SEL_W_DEF = 3;

   // Bits needed to hold the larger of the two reload values plus one.
   function automatic int timer_w(input int dwell, input int blank);
      int m;
      m = (dwell > blank) ? dwell : blank;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter; holds at zero until reloaded.
module dwell_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/scan_sequencer.sv
// Time-multiplexed scan driver for a 3-to-8 decoder: blank gap, then dwell, per slot.
// Defining SCAN_STEP_EN adds a `step` input for single-slot stepping while stopped.
module scan_sequencer
   import scan_pkg::*;
#(
   parameter int SEL_W        = SEL_W_DEF,
   parameter int DWELL_CYCLES = 1000,
   parameter int BLANK_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [SEL_W-1:0] last,
`ifdef SCAN_STEP_EN
   input  logic             step,
`endif
   output logic [SEL_W-1:0] sel,
   output logic             en,
   output logic             frame_done
);

   localparam int TW = timer_w(DWELL_CYCLES, BLANK_CYCLES);
   localparam logic [TW-1:0] DWELL_LD = TW'(DWELL_CYCLES - 1);
   localparam logic [TW-1:0] BLANK_LD = (BLANK_CYCLES > 0) ? TW'(BLANK_CYCLES - 1) : '0;
   localparam logic [TW-1:0] SLOT_LD  = (BLANK_CYCLES > 0) ? BLANK_LD : DWELL_LD;

   state_t           state;
   logic [SEL_W-1:0] last_q;
   logic             stepping;
   logic             step_go;
   logic             abort;
   logic             tmr_load;
   logic [TW-1:0]    tmr_val;
   logic             tmr_zero;

`ifdef SCAN_STEP_EN
   assign step_go = step;
`else
   assign step_go = 1'b0;
`endif

   // A stepped slot runs to completion even though run is low.
   assign abort = !run && !stepping;

   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = DWELL_LD;
      case (state)
         IDLE: begin
            if (run || step_go) begin
               tmr_load = 1'b1;
               tmr_val  = SLOT_LD;
            end
         end
         BLANK: begin
            if (!abort && tmr_zero) begin
               tmr_load = 1'b1;
               tmr_val  = DWELL_LD;
            end
         end
         ACTIVE: begin
            if (!abort && tmr_zero) begin
               tmr_load = 1'b1;
               tmr_val  = SLOT_LD;
            end
         end
         default: ;
      endcase
   end

   dwell_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sel        <= '0;
         en         <= 1'b0;
         frame_done <= 1'b0;
         last_q     <= '0;
         stepping   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               en <= 1'b0;
               if (run || step_go) begin
                  if (run) begin
                     sel    <= '0;
                     last_q <= last;
                  end else begin
                     stepping <= 1'b1;
                     if (sel == '0) last_q <= last;
                  end
                  if (BLANK_CYCLES == 0) begin
                     state <= ACTIVE;
                     en    <= 1'b1;
                  end else begin
                     state <= BLANK;
                  end
               end
            end
            BLANK: begin
               if (abort) begin
                  state <= IDLE;
                  en    <= 1'b0;
               end else if (tmr_zero) begin
                  state <= ACTIVE;
                  en    <= 1'b1;
               end
            end
            ACTIVE: begin
               if (abort) begin
                  state <= IDLE;
                  en    <= 1'b0;
               end else if (tmr_zero) begin
                  if (sel == last_q) begin
                     sel        <= '0;
                     last_q     <= last;
                     frame_done <= 1'b1;
                  end else begin
                     sel <= sel + 1'b1;
                  end
                  if (stepping) begin
                     state    <= IDLE;
                     en       <= 1'b0;
                     stepping <= 1'b0;
                  end else if (BLANK_CYCLES == 0) begin
                     en <= 1'b1;
                  end else begin
                     state <= BLANK;
                     en    <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               en    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_scan_sequencer.sv
// Randomised bench: two sequencer configurations compared every cycle against a slot/phase schedule model.
module tb_scan_sequencer;

   localparam int SW = 3;
`ifdef SCAN_STEP_EN
   localparam bit STEP_ON = 1'b1;
`else
   localparam bit STEP_ON = 1'b0;
`endif

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          run   = 1'b0;
   logic          step  = 1'b0;
   logic [SW-1:0] last  = '0;

   logic [SW-1:0] sel_a, sel_b;
   logic          en_a, en_b, fd_a, fd_b;

   always #5 clk = ~clk;

   scan_sequencer #(.SEL_W(SW), .DWELL_CYCLES(3), .BLANK_CYCLES(2)) dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (run),
      .last       (last),
`ifdef SCAN_STEP_EN
      .step       (step),
`endif
      .sel        (sel_a),
      .en         (en_a),
      .frame_done (fd_a)
   );

   scan_sequencer #(.SEL_W(SW), .DWELL_CYCLES(1), .BLANK_CYCLES(0)) dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (run),
      .last       (last),
`ifdef SCAN_STEP_EN
      .step       (step),
`endif
      .sel        (sel_b),
      .en         (en_b),
      .frame_done (fd_b)
   );

   // Schedule model: each slot is BLANK+DWELL clocks; phase counts clocks into the slot.
   int m_dwell[2] = '{3, 1};
   int m_blank[2] = '{2, 0};
   bit m_running[2];
   bit m_stepping[2];
   bit m_fd[2];
   int m_phase[2];
   int m_slot[2];
   int m_lastq[2];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_running[i]  = 0;
         m_stepping[i] = 0;
         m_fd[i]       = 0;
         m_phase[i]    = 0;
         m_slot[i]     = 0;
         m_lastq[i]    = 0;
      end
   endtask

   task automatic model_step(input bit r, input int l, input bit s);
      for (int i = 0; i < 2; i++) begin
         m_fd[i] = 0;
         if (!m_running[i]) begin
            if (r) begin
               m_running[i] = 1;
               m_slot[i]    = 0;
               m_lastq[i]   = l;
               m_phase[i]   = 0;
            end else if (s && STEP_ON) begin
               m_running[i]  = 1;
               m_stepping[i] = 1;
               if (m_slot[i] == 0) m_lastq[i] = l;
               m_phase[i] = 0;
            end
         end else if (!r && !m_stepping[i]) begin
            m_running[i] = 0;
         end else begin
            m_phase[i]++;
            if (m_phase[i] == m_blank[i] + m_dwell[i]) begin
               m_phase[i] = 0;
               if (m_slot[i] == m_lastq[i]) begin
                  m_slot[i]  = 0;
                  m_lastq[i] = l;
                  m_fd[i]    = 1;
               end else begin
                  m_slot[i]++;
               end
               if (m_stepping[i]) begin
                  m_running[i]  = 0;
                  m_stepping[i] = 0;
               end
            end
         end
      end
   endtask

   function automatic int exp_en(input int i);
      return (m_running[i] && m_phase[i] >= m_blank[i]) ? 1 : 0;
   endfunction

   task automatic compare_all(input string ctx);
      check({ctx, " a.sel"}, int'(sel_a), m_slot[0]);
      check({ctx, " a.en"},  int'(en_a),  exp_en(0));
      check({ctx, " a.frame_done"}, int'(fd_a), int'(m_fd[0]));
      check({ctx, " b.sel"}, int'(sel_b), m_slot[1]);
      check({ctx, " b.en"},  int'(en_b),  exp_en(1));
      check({ctx, " b.frame_done"}, int'(fd_b), int'(m_fd[1]));
   endtask

   task automatic cycle(input string ctx);
      @(posedge clk);
      if (rst_n) model_step(run, int'(last), step);
      @(negedge clk);
      compare_all(ctx);
   endtask

   initial begin
      bit found;
      model_reset();
      @(negedge clk);
      compare_all("reset");
      @(negedge clk);
      rst_n = 1'b1;
      cycle("idle");

      // Continuous scan over all eight slots
      last = 3'd7;
      run  = 1'b1;
      repeat (100) cycle("scan");

      // Short frames with last changing mid-frame
      last = 3'd2;
      repeat (20) cycle("short");
      last = 3'd5;
      repeat (60) cycle("relast");
      repeat (150) begin
         if ($urandom_range(0, 14) == 0) last = SW'($urandom);
         cycle("rand_last");
      end

      // Stop while slot 4 is lit, then restart
      last  = 3'd7;
      found = 0;
      for (int k = 0; k < 200 && !found; k++) begin
         cycle("seek");
         if (sel_a == 3'd4 && en_a) found = 1;
      end
      check("seek_sel4_timeout", int'(found), 1);
      run = 1'b0;
      cycle("stop");
      check("stop en_a", int'(en_a), 0);
      repeat (5) cycle("stopped");
      run = 1'b1;
      repeat (40) cycle("restart");

      // Random run toggling
      repeat (300) begin
         if ($urandom_range(0, 24) == 0) run = ~run;
         if ($urandom_range(0, 19) == 0) last = SW'($urandom);
         cycle("rand_run");
      end

      // Zero-blanking configuration with last=3
      run  = 1'b0;
      cycle("pre_zb");
      last = 3'd3;
      run  = 1'b1;
      repeat (20) cycle("zero_blank");

      // Asynchronous reset between edges
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      compare_all("async_rst");
      repeat (3) cycle("in_rst");
      run = 1'b0;
      rst_n = 1'b1;
      repeat (5) cycle("post_rst_idle");

      // Stepping while stopped; pulses during a running slot must be ignored
      last = 3'd1;
      repeat (250) begin
         step = ($urandom_range(0, 6) == 0);
         cycle("step");
      end
      step = 1'b0;
      repeat (10) cycle("step_end");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
